// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
//   Time-multiplexed seven-segment scan controller for NUM_DIGITS hex digits
//   sharing one active-low cathode bus.
//
//   Each digit owns a slot of 2^SLOT_W clocks. A slot starts with
//   BLANK_CYCLES of dead time so the previous digit's image cannot ghost onto
//   the next one. After the dead time the anode is held low only while the top
//   four bits of the slot counter are <= the brightness value, which gives
//   in-slot PWM.
//
//   Display data is captured once per frame, in the last cycle of the last
//   slot. This keeps a frame visually consistent even if the game logic
//   updates its outputs mid-scan. Brightness is sampled at every slot start.
//   Leading-zero blanking is resolved at capture time and stored as a
//   per-digit visibility mask.
//
// Parameters
//   NUM_DIGITS   : number of digits / anodes (2..8)
//   SLOT_W       : slot length is 2^SLOT_W clocks (>= 6)
//   BLANK_CYCLES : dead time at slot start; must be < 2^(SLOT_W-4)
//
// Ports
//   Clk        : system clock
//   Reset_n    : asynchronous active-low reset
//   digits_in  : hex nibble per digit, digit i = [4i+3:4i]
//   dp_in      : decimal point request per digit (1 = lit)
//   digit_en   : per-digit enable (0 = always dark)
//   bright     : brightness, 0 = dimmest (still on) .. 15 = full slot
//   lz_blank   : leading-zero blanking enable
//   An         : anodes, active-low, registered
//   Seg        : cathodes {a,b,c,d,e,f,g}, active-low, registered
//   Dp         : decimal point cathode, active-low, registered
//   digit_idx  : digit currently being scanned (counter-aligned)
//   frame_tick : one-cycle pulse in the shadow-capture cycle
module ssd_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int SLOT_W       = 18,
   parameter int BLANK_CYCLES = 1024,
   parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [3:0]              bright,
   input  logic                    lz_blank,
   output logic [NUM_DIGITS-1:0]   An,
   output logic [6:0]              Seg,
   output logic                    Dp,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_tick
);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);

   // Hex to active-low {a,b,c,d,e,f,g}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Counters
   logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;

   // Shadow state
   logic [4*NUM_DIGITS-1:0] digits_sh_q, digits_sh_d;
   logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [NUM_DIGITS-1:0]   vis_sh_q, vis_sh_d;
   logic [3:0]              bright_sh_q, bright_sh_d;

   // Registered pin drivers
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_pin_q, dp_pin_d;

   // Combinational helpers
   logic                    slot_wrap;
   logic                    last_digit;
   logic                    frame_cap;
   logic                    nz_above;
   logic [NUM_DIGITS-1:0]   suppress;
   logic [NUM_DIGITS-1:0]   vis_cap;
   logic [3:0]              cur_nib;
   logic                    cur_dp;
   logic                    cur_vis;
   logic                    lit;

   // Leading-zero suppression from the live inputs; only used in the capture
   // cycle, where live inputs and the new shadow values are the same thing.
   // Scanning from the top, a digit is a leading zero while no nonzero nibble
   // has been seen at or above it.
   always_comb begin
      nz_above = 1'b0;
      suppress = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz_above    = nz_above | (digits_in[4*i +: 4] != 4'h0);
         suppress[i] = lz_blank && (i != 0) && !nz_above && !dp_in[i];
      end
      vis_cap = digit_en & ~suppress;
   end

   always_comb begin
      slot_wrap  = (slot_cnt_q == '1);
      last_digit = (digit_idx_q == LAST_IDX);
      frame_cap  = slot_wrap && last_digit;

      slot_cnt_d  = slot_cnt_q + SLOT_W'(1);
      digit_idx_d = digit_idx_q;
      if (slot_wrap) begin
         digit_idx_d = last_digit ? '0 : digit_idx_q + IDX_W'(1);
      end

      bright_sh_d = slot_wrap ? bright : bright_sh_q;
      digits_sh_d = frame_cap ? digits_in : digits_sh_q;
      dp_sh_d     = frame_cap ? dp_in : dp_sh_q;
      vis_sh_d    = frame_cap ? vis_cap : vis_sh_q;

      // Mux out the shadow data of the digit being scanned
      cur_nib = 4'h0;
      cur_dp  = 1'b0;
      cur_vis = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx_q == IDX_W'(i)) begin
            cur_nib = digits_sh_q[4*i +: 4];
            cur_dp  = dp_sh_q[i];
            cur_vis = vis_sh_q[i];
         end
      end

      // Dead time first, then PWM on the top four slot-counter bits
      lit = cur_vis && (slot_cnt_q >= BLANK_END) &&
            (slot_cnt_q[SLOT_W-1 -: 4] <= bright_sh_q);

      an_d     = '1;
      seg_d    = 7'b1111111;
      dp_pin_d = 1'b1;
      if (lit) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
               an_d[i] = 1'b0;
            end
         end
         seg_d    = hex_to_seg(cur_nib);
         dp_pin_d = ~cur_dp;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         slot_cnt_q  <= '0;
         digit_idx_q <= '0;
         digits_sh_q <= '0;
         dp_sh_q     <= '0;
         vis_sh_q    <= '0;
         bright_sh_q <= '0;
         an_q        <= '1;
         seg_q       <= 7'b1111111;
         dp_pin_q    <= 1'b1;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         digit_idx_q <= digit_idx_d;
         digits_sh_q <= digits_sh_d;
         dp_sh_q     <= dp_sh_d;
         vis_sh_q    <= vis_sh_d;
         bright_sh_q <= bright_sh_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_pin_q    <= dp_pin_d;
      end
   end

   assign An         = an_q;
   assign Seg        = seg_q;
   assign Dp         = dp_pin_q;
   assign digit_idx  = digit_idx_q;
   assign frame_tick = frame_cap;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Testbench for ssd_scan_ctrl with NUM_DIGITS=4, SLOT_W=6, BLANK_CYCLES=2.
// A cycle model predicts every output word after each clock edge and queues
// it; a negedge monitor pops and compares. Directed frame scans additionally
// measure per-digit on-time, decoded segments and decimal points.
module tb_ssd_scan_ctrl;

   localparam int ND = 4;
   localparam int SW = 6;
   localparam int BC = 2;
   localparam int SLOT = 1 << SW;
   localparam int FRAME = ND * SLOT;

   logic          Clk;
   logic          Reset_n;
   logic [15:0]   digits_in;
   logic [3:0]    dp_in;
   logic [3:0]    digit_en;
   logic [3:0]    bright;
   logic          lz_blank;
   logic [3:0]    An;
   logic [6:0]    Seg;
   logic          Dp;
   logic [1:0]    digit_idx;
   logic          frame_tick;

   ssd_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .SLOT_W       (SW),
      .BLANK_CYCLES (BC)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .bright     (bright),
      .lz_blank   (lz_blank),
      .An         (An),
      .Seg        (Seg),
      .Dp         (Dp),
      .digit_idx  (digit_idx),
      .frame_tick (frame_tick)
   );

   // ---------------- clock ----------------
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   // Word layout: {An[3:0], Seg[6:0], Dp, digit_idx[1:0], frame_tick}
   logic [14:0] exp_q[$];
   logic [6:0]  seg_tab [16];
   logic [3:0]  m_dig [ND];
   logic [3:0]  m_dp, m_vis, m_bright;
   int          m_cnt, m_s, m_d, m_h;
   logic [3:0]  m_an;
   logic [6:0]  m_seg;
   logic        m_dpo;

   initial begin
      seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
      seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
      seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
      seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
      seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
      seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
   end

   // m_cnt = clocks since reset release; slot position and digit follow from it
   initial begin
      forever begin
         @(posedge Clk or negedge Reset_n);
         if (!Reset_n) begin
            m_cnt = 0;
            m_dp = '0; m_vis = '0; m_bright = '0;
            for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
            exp_q.delete();
         end else begin
            // pins after this edge reflect the state before it
            m_s = m_cnt % SLOT;
            m_d = (m_cnt / SLOT) % ND;
            m_an = 4'hF; m_seg = 7'h7F; m_dpo = 1'b1;
            if (m_vis[m_d] && m_s >= BC && (m_s >> (SW - 4)) <= int'(m_bright)) begin
               m_an[m_d] = 1'b0;
               m_seg = seg_tab[m_dig[m_d]];
               m_dpo = ~m_dp[m_d];
            end
            if (m_s == SLOT - 1) m_bright = bright;
            if (m_s == SLOT - 1 && m_d == ND - 1) begin
               m_h = -1;
               for (int i = 0; i < ND; i++) begin
                  m_dig[i] = digits_in[4*i +: 4];
                  if (digits_in[4*i +: 4] != 4'h0) m_h = i;
               end
               m_dp = dp_in;
               for (int i = 0; i < ND; i++)
                  m_vis[i] = digit_en[i] && !(lz_blank && i != 0 && i > m_h && !dp_in[i]);
            end
            m_cnt++;
            m_s = m_cnt % SLOT;
            m_d = (m_cnt / SLOT) % ND;
            exp_q.push_back({m_an, m_seg, m_dpo, 2'(m_d), 1'(m_s == SLOT - 1 && m_d == ND - 1)});
         end
      end
   end

   initial begin
      logic [14:0] e;
      forever begin
         @(negedge Clk);
         if (Reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scan", {17'h0, An, Seg, Dp, digit_idx, frame_tick}, {17'h0, e});
         end
      end
   end

   // ---------------- driver / measurement tasks ----------------
   int         on_cnt [ND];
   logic [6:0] seg_seen [ND];
   logic       dp_seen [ND];
   int         multi_low;

   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!frame_tick && n < 2 * FRAME + 8);
      check("tick_wait", 32'(frame_tick), 32'd1);
   endtask

   // Called at the negedge where frame_tick is high; samples exactly the
   // pin values produced by the next frame's states.
   task automatic scan_body(input int change_at, input logic [15:0] change_val);
      @(negedge Clk);
      multi_low = 0;
      for (int i = 0; i < ND; i++) begin
         on_cnt[i] = 0; seg_seen[i] = 7'h7F; dp_seen[i] = 1'b1;
      end
      for (int k = 0; k < FRAME; k++) begin
         @(negedge Clk);
         for (int i = 0; i < ND; i++) begin
            if (!An[i]) begin
               on_cnt[i]++;
               seg_seen[i] = Seg;
               dp_seen[i] = Dp;
            end
         end
         if ($countones(~An) > 1) multi_low++;
         if (k == change_at) digits_in = change_val;
      end
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      int lit, tick_at, n;
      Reset_n = 1'b1;
      digits_in = '0; dp_in = '0; digit_en = '0; bright = '0; lz_blank = 1'b0;
      #1 Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_an", 32'(An), 32'hF);
      check("rst_seg", 32'(Seg), 32'h7F);
      check("rst_dp", 32'(Dp), 32'd1);
      check("rst_tick", 32'(frame_tick), 32'd0);
      check("rst_idx", 32'(digit_idx), 32'd0);

      // first frame dark, tick after 255 clocks
      digits_in = 16'h3A0F; bright = 4'd15; dp_in = 4'b0100; digit_en = 4'hF;
      Reset_n = 1'b1;
      lit = 0; tick_at = -1;
      for (int k = 1; k <= FRAME - 1; k++) begin
         @(negedge Clk);
         if (An != 4'hF || Seg != 7'h7F) lit++;
         if (frame_tick && tick_at < 0) tick_at = k;
      end
      check("first_frame_dark", 32'(lit), 32'd0);
      check("first_tick", 32'(tick_at), 32'd255);

      // hex decode, full brightness
      scan_body(-1, 16'h0);
      check("hex_on0", 32'(on_cnt[0]), 32'd62);
      check("hex_on3", 32'(on_cnt[3]), 32'd62);
      check("hex_seg0", 32'(seg_seen[0]), 32'b0111000);
      check("hex_seg1", 32'(seg_seen[1]), 32'b0000001);
      check("hex_seg2", 32'(seg_seen[2]), 32'b0001000);
      check("hex_seg3", 32'(seg_seen[3]), 32'b0000110);
      check("hex_dp2", 32'(dp_seen[2]), 32'd0);
      check("hex_dp0", 32'(dp_seen[0]), 32'd1);
      check("hex_one_anode", 32'(multi_low), 32'd0);

      // brightness 3 and 0
      bright = 4'd3;
      wait_tick();
      scan_body(-1, 16'h0);
      check("bright3_on1", 32'(on_cnt[1]), 32'd14);
      check("bright3_on2", 32'(on_cnt[2]), 32'd14);
      bright = 4'd0;
      wait_tick();
      scan_body(-1, 16'h0);
      check("bright0_on0", 32'(on_cnt[0]), 32'd2);
      check("bright0_on3", 32'(on_cnt[3]), 32'd2);

      // frame coherence: mid-frame change invisible until next capture
      bright = 4'd15; digits_in = 16'h1111; dp_in = 4'b0000;
      wait_tick();
      scan_body(100, 16'h2222);
      for (int i = 0; i < ND; i++) check("coh_old", 32'(seg_seen[i]), 32'b1001111);
      wait_tick();
      scan_body(-1, 16'h0);
      for (int i = 0; i < ND; i++) check("coh_new", 32'(seg_seen[i]), 32'b0010010);

      // digit enable
      digit_en = 4'b1011; digits_in = 16'h8888;
      wait_tick();
      scan_body(-1, 16'h0);
      check("en_off2", 32'(on_cnt[2]), 32'd0);
      check("en_on3", 32'(on_cnt[3]), 32'd62);
      digit_en = 4'hF;

      // leading-zero blanking
      lz_blank = 1'b1; digits_in = 16'h0005;
      wait_tick();
      scan_body(-1, 16'h0);
      check("lz5_on0", 32'(on_cnt[0]), 32'd62);
      check("lz5_seg0", 32'(seg_seen[0]), 32'b0100100);
      check("lz5_dark", 32'(on_cnt[1] + on_cnt[2] + on_cnt[3]), 32'd0);
      digits_in = 16'h0000;
      wait_tick();
      scan_body(-1, 16'h0);
      check("lz0_on0", 32'(on_cnt[0]), 32'd62);
      check("lz0_seg0", 32'(seg_seen[0]), 32'b0000001);
      check("lz0_dark", 32'(on_cnt[1] + on_cnt[2] + on_cnt[3]), 32'd0);
      digits_in = 16'h0005; dp_in = 4'b0100;
      wait_tick();
      scan_body(-1, 16'h0);
      check("lzdp_on0", 32'(on_cnt[0]), 32'd62);
      check("lzdp_on2", 32'(on_cnt[2]), 32'd62);
      check("lzdp_seg2", 32'(seg_seen[2]), 32'b0000001);
      check("lzdp_dp2", 32'(dp_seen[2]), 32'd0);
      check("lzdp_dark", 32'(on_cnt[1] + on_cnt[3]), 32'd0);

      // asynchronous reset while digit 1 is lit
      lz_blank = 1'b0; digits_in = 16'h1234; dp_in = 4'b0000;
      wait_tick();
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (An != 4'b1101 && n < FRAME);
      check("mid_an_seen", 32'(An), 32'b1101);
      #2 Reset_n = 1'b0;
      #1;
      check("async_an", 32'(An), 32'hF);
      check("async_idx", 32'(digit_idx), 32'd0);
      check("async_seg", 32'(Seg), 32'h7F);
      check("async_dp", 32'(Dp), 32'd1);
      @(negedge Clk);
      Reset_n = 1'b1;
      lit = 0;
      for (int k = 0; k < SLOT + 10; k++) begin
         @(negedge Clk);
         if (An != 4'hF) lit++;
      end
      check("post_reset_dark", 32'(lit), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
